// File: rtl/clk_div_prog.sv
// Programmable clock divider: pulse or square output, divisor updates land on period boundaries.
// div_out is registered from next-state so it lines up with the cycle's count; loads handshake via div_ready.
module clk_div_prog #(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ready,
  output logic             div_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_active
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             mode_q, mode_d;
  logic             out_q, out_d;

  logic running;
  logic bnd;
  logic apply;
  logic accept;
  logic restart;

  // Output shape for a given count; used for the next-state register value.
  function automatic logic out_fn(input logic             run,
                                  input logic [CNT_W-1:0] d,
                                  input logic [CNT_W-1:0] c,
                                  input logic             sq);
    logic [CNT_W:0] half;
    logic           res;
    half = ({1'b0, d} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    res  = 1'b0;
    if (run && d != '0) begin
      if (sq && d > ONE) res = ({1'b0, c} < half);
      else               res = (c == '0);
    end
    return res;
  endfunction

  always_comb begin
    running = (state_q == ST_RUN);
    bnd     = !running || (div_q <= ONE) || (cnt_q == div_q - ONE);
    apply   = pend_q && bnd;
    accept  = div_load && !pend_q;
    restart = !en || bnd;
  end

  // Divisor handshake: apply wins, and accept is only possible when nothing is pending.
  always_comb begin
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    if (apply) begin
      div_d  = pdiv_q;
      pend_d = 1'b0;
    end else if (accept) begin
      pdiv_d = div_val;
      pend_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_STOP;
      cnt_d   = '0;
    end else if (!running) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (bnd) begin
      cnt_d   = '0;
    end else begin
      cnt_d   = cnt_q + ONE;
    end
  end

  always_comb begin
    mode_d = restart ? mode : mode_q;
    out_d  = out_fn(state_d == ST_RUN, div_d, cnt_d, mode_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      div_q   <= DIV_RST_V;
      pdiv_q  <= '0;
      pend_q  <= 1'b0;
      mode_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign div_out    = out_q;
  assign div_ready  = !pend_q;
  assign div_active = div_q;
  assign tick       = running && (div_q != '0) && (cnt_q == div_q - ONE);

  a_out_aligned: assert property (@(posedge clk) disable iff (!nrst)
    div_out == out_fn(state_q == ST_RUN, div_q, cnt_q, mode_q));

  a_cnt_range: assert property (@(posedge clk) disable iff (!nrst)
    (state_q == ST_RUN && div_q != '0) |-> (cnt_q < div_q));

  a_halt_zero: assert property (@(posedge clk) disable iff (!nrst)
    (div_q == '0) |-> (cnt_q == '0 && !div_out && !tick));

  a_tick_run: assert property (@(posedge clk) disable iff (!nrst)
    tick |-> (state_q == ST_RUN));

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized and directed bench for clk_div_prog against a cycle-level behavioural model.
module tb_clk_div_prog;

  logic       clk;
  logic       nrst;
  logic       en;
  logic       mode;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_ready;
  logic       div_out;
  logic       tick;
  logic [7:0] div_active;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: running flag, position within period, active/pending divisor, latched mode.
  int m_run, m_pos, m_d, m_p, m_pend, m_mode;

  clk_div_prog #(.CNT_W(8), .DIV_RST(2)) dut (
    .clk(clk), .nrst(nrst), .en(en), .mode(mode),
    .div_val(div_val), .div_load(div_load),
    .div_ready(div_ready), .div_out(div_out), .tick(tick), .div_active(div_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_d = 2; m_p = 0; m_pend = 0; m_mode = 0;
  endtask

  task automatic model_edge(input logic e, input logic md, input int dv, input logic dl);
    int b;
    b = (m_run == 0) || (m_d <= 1) || (m_pos == m_d - 1);
    if (m_pend && b) begin
      m_d = m_p; m_pend = 0;
    end else if (dl && !m_pend) begin
      m_p = dv; m_pend = 1;
    end
    if (!e || b) m_mode = md;
    if (!e)          begin m_run = 0; m_pos = 0; end
    else if (!m_run) begin m_run = 1; m_pos = 0; end
    else if (b)      m_pos = 0;
    else             m_pos = m_pos + 1;
  endtask

  task automatic check_outputs(input string tag);
    logic e_out, e_tick;
    e_tick = (m_run != 0) && (m_d >= 1) && (m_pos == m_d - 1);
    e_out  = 1'b0;
    if (m_run != 0 && m_d >= 1) begin
      if (m_mode != 0 && m_d >= 2) e_out = (m_pos < (m_d + 1) / 2);
      else                         e_out = (m_pos == 0);
    end
    chk({tag, "_out"},    32'(div_out),    32'(e_out));
    chk({tag, "_tick"},   32'(tick),       32'(e_tick));
    chk({tag, "_ready"},  32'(div_ready),  32'(m_pend == 0));
    chk({tag, "_active"}, 32'(div_active), 32'(m_d));
  endtask

  // Called at a negedge; drives one cycle and checks the following cycle.
  task automatic cycle(input logic e, input logic md, input logic [7:0] dv, input logic dl, input string tag);
    en = e; mode = md; div_val = dv; div_load = dl;
    model_edge(e, md, int'(dv), dl);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(negedge clk);
    check_outputs("rst_hold");
    nrst = 1'b1;
  endtask

  task automatic wait_apply(input logic md, input string tag);
    for (int i = 0; i < 300 && m_pend != 0; i++) cycle(1'b1, md, 8'd0, 1'b0, tag);
    chk({tag, "_applied"}, 32'(div_ready), 32'd1);
  endtask

  task automatic run_to_pos(input int p, input logic md, input string tag);
    int reached;
    reached = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_pos == p && m_run != 0) begin reached = 1; break; end
      cycle(1'b1, md, 8'd0, 1'b0, tag);
    end
    chk({tag, "_pos_wait"}, 32'(reached), 32'd1);
  endtask

  initial begin
    int lo_cnt, exp_lo;
    logic cur_mode, e, dl;
    logic [7:0] dv;

    nrst = 1'b0; en = 1'b0; mode = 1'b0; div_val = '0; div_load = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");

    // Square at D=2 from reset release.
    en = 1'b1; mode = 1'b1;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 8'd0, 1'b0, "d2");
      chk("d2_pattern_out",  32'(div_out), 32'(i % 2 == 0));
      chk("d2_pattern_tick", 32'(tick),    32'(i % 2 == 1));
    end

    // D=5 square.
    cycle(1'b1, 1'b1, 8'd5, 1'b1, "d5_load");
    wait_apply(1'b1, "d5");
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 8'd0, 1'b0, "d5");

    // D=4 pulse.
    cycle(1'b1, 1'b0, 8'd4, 1'b1, "d4_load");
    wait_apply(1'b0, "d4");
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'd0, 1'b0, "d4");

    // D=7 loaded mid-period of D=5; a second load while busy is dropped.
    cycle(1'b1, 1'b1, 8'd5, 1'b1, "d57_load5");
    wait_apply(1'b1, "d57_a");
    run_to_pos(2, 1'b1, "d57");
    exp_lo = m_d - 1 - m_pos;
    lo_cnt = 0;
    cycle(1'b1, 1'b1, 8'd7, 1'b1, "d57_load7");
    if (!div_ready) lo_cnt++;
    cycle(1'b1, 1'b1, 8'd3, 1'b1, "d57_load3");
    if (!div_ready) lo_cnt++;
    for (int i = 0; i < 20 && !div_ready; i++) begin
      cycle(1'b1, 1'b1, 8'd0, 1'b0, "d57_wait");
      if (!div_ready) lo_cnt++;
    end
    chk("d57_ready_low_cycles", 32'(lo_cnt), 32'(exp_lo));
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 8'd0, 1'b0, "d7");
    chk("d57_active_is_7", 32'(div_active), 32'd7);

    // Stop for three cycles mid-period, then restart.
    run_to_pos(3, 1'b1, "stop");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'd0, 1'b0, "stop");
      chk("stop_out_low",  32'(div_out), 32'd0);
      chk("stop_tick_low", 32'(tick),    32'd0);
    end
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 8'd0, 1'b0, "restart");

    // D=0 halts, then D=1 gives a constant high.
    cycle(1'b1, 1'b1, 8'd0, 1'b1, "d0_load");
    wait_apply(1'b1, "d0");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 8'd0, 1'b0, "d0");
      chk("d0_out_low", 32'(div_out), 32'd0);
    end
    cycle(1'b1, 1'b1, 8'd1, 1'b1, "d1_load");
    cycle(1'b1, 1'b1, 8'd0, 1'b0, "d1_apply");
    chk("d1_active", 32'(div_active), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 8'd0, 1'b0, "d1");
      chk("d1_out_high", 32'(div_out), 32'd1);
    end

    // Mode flip mid-period only takes effect at the next boundary.
    cycle(1'b1, 1'b0, 8'd6, 1'b1, "mflip_load");
    wait_apply(1'b0, "mflip");
    run_to_pos(1, 1'b0, "mflip");
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1, 8'd0, 1'b0, "mflip");

    // Reset with a load pending.
    cycle(1'b1, 1'b1, 8'd9, 1'b1, "rstpend_load");
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 8'd0, 1'b0, "rstpend");

    // Random traffic.
    cur_mode = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      e  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) cur_mode = ~cur_mode;
      dl = ($urandom_range(0, 5) == 0);
      dv = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 9));
      cycle(e, cur_mode, dv, dl, "rnd");
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter CNT_W, default 8: width of the divisor and of the internal period counter.
REQ-002 Parameter DIV_RST, default 2: active divisor loaded at reset; must fit in CNT_W bits.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 nrst  input  1: reset, asynchronous and active-low.
REQ-005 en  input  1: run enable; 1 = divider counting, 0 = divider stopped.
REQ-006 mode  input  1: output shape; 0 = pulse (one-cycle high per period), 1 = square (near-50% duty).
REQ-007 div_val  input  CNT_W: requested divisor D, unsigned.
REQ-008 div_load  input  1: request to load div_val; accepted when div_load=1 and div_ready=1 at a posedge.
REQ-009 div_ready  output  1: 1 when no divisor update is pending.
REQ-010 div_out  output  1: divided clock; driven directly from a flop, never from combinational logic.
REQ-011 tick  output  1: 1 during the last cycle of every period.
REQ-012 div_active  output  CNT_W: divisor currently in effect.

Function
REQ-013 State: counter cnt (CNT_W bits), run flag, active divisor D, pending divisor P, pending flag pend.
REQ-014 Boundary condition B in a cycle: (run=0) or (D<=1) or (cnt==D-1).
REQ-015 en=0 at an edge: run<=0, cnt<=0, div_out<=0; tick is 0 while run=0.
REQ-016 en=1 and run=0 at an edge: run<=1, cnt<=0; the new period starts phase-aligned in the next cycle.
REQ-017 en=1 and run=1: cnt<=0 if B, else cnt<=cnt+1; cnt never exceeds D-1 and never wraps through 2^CNT_W.
REQ-018 Pulse mode, run=1, D>=1: div_out=1 exactly in cycles with cnt==0; D=1 gives div_out constantly 1.
REQ-019 Square mode, run=1, D>=2: div_out=1 iff cnt < ceil(D/2); high ceil(D/2) cycles, low floor(D/2) cycles.
REQ-020 Square mode with D=1 behaves as pulse mode (div_out constantly 1).
REQ-021 D=0: divider halted; cnt held 0, div_out 0, tick 0, regardless of en and mode.
REQ-022 tick=1 iff run=1, D>=1 and cnt==D-1; combinational from registered state.
REQ-023 div_out must be registered so that its value in a cycle matches REQ-018/019 for that cycle's cnt; no extra latency.
REQ-024 Load accept: at an edge with div_load=1 and div_ready=1, P<=div_val, pend<=1; div_ready drops the next cycle.
REQ-025 Apply: at an edge where pend=1 and B is true in the preceding cycle, D<=P, pend<=0, cnt<=0; div_ready returns to 1 the next cycle.
REQ-026 A value accepted at edge E is never applied at E itself; earliest apply is the next edge with B true.
REQ-027 div_load while div_ready=0 is ignored; P is not overwritten.
REQ-028 mode change takes effect at the next period boundary only; mode is sampled into a register when cnt<=0 is loaded.
REQ-029 div_active reflects D; changes only on apply or reset.
REQ-030 No glitch or truncated high phase on div_out during a divisor change: the current period completes with the old D.

Reset
REQ-031 nrst low asynchronously forces: cnt=0, run=0, D=DIV_RST, P=0, pend=0, registered mode=0, div_out=0.
REQ-032 During reset: div_out=0, tick=0, div_ready=1, div_active=DIV_RST.
REQ-033 Reset mid-period or with a pending load discards the pending divisor; after release, behaviour restarts per REQ-016.

Verification
REQ-034 Reset release, en=1, mode=1, D=DIV_RST=2 -> div_out toggles 1,0,1,0 from the second cycle after release; tick on every cnt=1 cycle.
REQ-035 Load D=5, mode=1 -> after the current period ends, div_out repeats high 3 cycles, low 2 cycles; tick in each low-phase 2nd cycle.
REQ-036 Load D=4, mode=0 -> div_out high 1 of every 4 cycles, coincident with cnt=0; tick in the cycle preceding each high.
REQ-037 Load D=7 mid-period of D=5, then assert div_load with D=3 while div_ready=0 -> the D=5 period completes intact, D=7 applies, 3 is ignored; div_ready low for exactly accept-to-apply cycles.
REQ-038 Drop en for 3 cycles mid-period, then raise -> div_out=0 and tick=0 while stopped; restart at cnt=0 with a full first period.
REQ-039 Load D=0 then D=1 -> div_out held 0 while D=0, then constant 1; D=0 applies at the first boundary, D=1 at the next edge.
